fetch_pc_gen: RTL and testbench
===============================

FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

Interface
REQ-001 Parameter FETCH_WIDTH, default 2: instructions per fetch group (1, 2 or 4); group size is FETCH_WIDTH*4 bytes.
REQ-002 Parameter Q_DEPTH, default 4: entries in the issued-request queue (power of two, 2..8).
REQ-003 Parameter RESET_PC, default 32'hBFC00000: first fetch address after reset.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 eret_valid  in  1 / eret_pc  in  32  return from exception to eret_pc.
REQ-007 ex_flush  in  1 / ex_pc  in  32  exception redirect to ex_pc.
REQ-008 br_redirect  in  1 / br_target  in  32  branch-mispredict correction from execute.
REQ-009 bpu_valid  in  1 / bpu_target  in  32  predicted-taken target for the group accepted this cycle.
REQ-010 req_valid  out  1 / req_ready  in  1 / req_pc  out  32  ICache request handshake; req_pc[3:0] offset, [11:4] index, [31:12] tag.
REQ-011 out_valid  out  1 / out_ready  in  1  queue-head handshake to fetch stage.
REQ-012 out_pc  out  32 / out_mask  out  FETCH_WIDTH / out_ex  out  1 / out_exccode  out  5  queue-head group metadata.

Function
REQ-013 PC register holds the next fetch address; req_pc SHALL equal it combinationally.
REQ-014 Redirect priority SHALL be eret_valid > ex_flush > br_redirect > bpu_valid > sequential.
REQ-015 Any of eret_valid, ex_flush, br_redirect SHALL load the PC with its target at the next edge, regardless of req_ready, and clear the queue in that same cycle.
REQ-016 A request accepted (req_valid & req_ready) in a redirect cycle SHALL NOT be pushed; the redirect wins.
REQ-017 On accept without redirect, next PC SHALL be bpu_target if bpu_valid, else (req_pc aligned down to group size) + FETCH_WIDTH*4, modulo 2^32.
REQ-018 out_mask lane i SHALL be 1 iff i >= req_pc word offset within group (e.g. FETCH_WIDTH=2, pc[2]=1 -> 2'b10).
REQ-019 req_valid SHALL be 1 only when not in reset, queue not full, no fault hold, and req_pc[1:0]==0.
REQ-020 If req_pc[1:0]!=0 and queue not full, one entry SHALL be pushed with out_ex=1, out_exccode=5'h04 (AdEL), out_mask all-ones, no ICache request; the block then enters FAULT and holds PC.
REQ-021 States: RUN, FAULT. RUN->FAULT per REQ-020; FAULT->RUN only on eret_valid, ex_flush or br_redirect; in FAULT req_valid=0.
REQ-022 Queue: push on accept (REQ-016/020), pop on out_valid & out_ready; simultaneous push and pop SHALL keep count unchanged, including at full.
REQ-023 out_valid SHALL be 1 iff queue non-empty; out_* SHALL reflect the head entry, first-in first-out.
REQ-024 Entry latency: group accepted at edge N SHALL be visible at queue head after edge N if queue was empty.
REQ-025 Read and write pointers SHALL wrap modulo Q_DEPTH; count SHALL range 0..Q_DEPTH.

Reset
REQ-026 While resetn=0: PC=RESET_PC, state RUN, queue empty, req_valid=0, out_valid=0, out_pc=0, out_mask=0, out_ex=0, out_exccode=0.
REQ-027 Reset asserted mid-operation SHALL discard all queued and pending state immediately; first request after release uses RESET_PC.

Structure
REQ-028 RESET_PC default, exception code AdEL=5'h04, NO_EX, and queue-entry field widths SHALL live in the shared global defines package.
REQ-029 Queue SHALL be a separate sub-module fetch_pc_fifo (parameters WIDTH, DEPTH; push/pop/flush/full/empty/count).

Verification
REQ-030 Reset release, req_ready=1, out_ready=1 -> req_pc 0xBFC00000, 0xBFC00008, 0xBFC00010; out_mask 2'b11 each.
REQ-031 br_redirect to 0x80000004 -> next req_pc 0x80000004, out_mask 2'b10, following req_pc 0x80000008; queue emptied on redirect cycle.
REQ-032 out_ready=0, req_ready=1, Q_DEPTH=4 -> exactly 4 accepts, then req_valid=0; one pop -> one more accept.
REQ-033 br_redirect to 0x80000002 -> entry out_ex=1, out_exccode=5'h04, req_valid held 0 until ex_flush to 0xBFC00380, then req_pc 0xBFC00380.
REQ-034 eret_valid (0x80001000), ex_flush, br_redirect same cycle as accept -> next req_pc 0x80001000, no push that cycle.
REQ-035 resetn low with 3 queued entries -> out_valid=0 immediately; after release req_pc 0xBFC00000.

Source files
------------

// File: rtl/fetch_pc_gen_pkg.sv
// Shared constants for the fetch PC generator: reset vector, exception codes,
// queue-entry field widths and the control FSM encoding.
package fetch_pc_gen_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC00000;
  localparam logic [4:0]  EXC_ADEL     = 5'h04;
  localparam logic [4:0]  EXC_NO_EX    = 5'h00;

  localparam int PC_W  = 32;
  localparam int EX_W  = 1;
  localparam int EXC_W = 5;

  // Entry layout (msb..lsb): {pc, mask[FETCH_WIDTH-1:0], ex, exccode}
  function automatic int entry_w(input int fetch_width);
    return PC_W + fetch_width + EX_W + EXC_W;
  endfunction

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_e;

endpackage

// File: rtl/fetch_pc_fifo.sv
// Issued-request queue: power-of-two depth, naturally wrapping pointers,
// flush clears everything and wins over push/pop in the same cycle.
module fetch_pc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot the push needs, so push-at-full is legal with a pop.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = PTR_W'(wr_q + 1'b1);
      if (do_pop)  rd_d = PTR_W'(rd_q + 1'b1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = CNT_W'(cnt_q + 1'b1);
        2'b01:   cnt_d = CNT_W'(cnt_q - 1'b1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: redirect arbitration, sequential/predicted next-PC,
// misaligned-PC fault capture and the issued-request queue.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int          FETCH_WIDTH = 2,
  parameter int          Q_DEPTH     = 4,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   eret_valid,
  input  logic [31:0]            eret_pc,
  input  logic                   ex_flush,
  input  logic [31:0]            ex_pc,
  input  logic                   br_redirect,
  input  logic [31:0]            br_target,
  input  logic                   bpu_valid,
  input  logic [31:0]            bpu_target,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [31:0]            req_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [FETCH_WIDTH-1:0] out_mask,
  output logic                   out_ex,
  output logic [4:0]             out_exccode
);

  localparam int          ENT_W     = entry_w(FETCH_WIDTH);
  localparam int          CNT_W     = $clog2(Q_DEPTH + 1);
  localparam logic [31:0] GRP_BYTES = 32'(FETCH_WIDTH * 4);

  logic [31:0]            pc_q, pc_d, redir_pc, word_off;
  state_e                 state_q, state_d;
  logic                   hard_redir, misalign, accept, fault_push, push, pop;
  logic                   q_full, q_empty;
  logic [CNT_W-1:0]       q_count;
  logic [FETCH_WIDTH-1:0] lane_mask, push_mask;
  logic [ENT_W-1:0]       push_ent, head_ent;

  assign hard_redir = eret_valid | ex_flush | br_redirect;
  assign redir_pc   = eret_valid ? eret_pc : (ex_flush ? ex_pc : br_target);
  assign misalign   = (pc_q[1:0] != 2'b00);
  assign word_off   = (pc_q >> 2) & (32'(FETCH_WIDTH) - 32'd1);

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_lane
    assign lane_mask[g] = (32'(g) >= word_off);
  end

  assign req_pc     = pc_q;
  assign req_valid  = resetn && !q_full && (state_q == ST_RUN) && !misalign;
  assign accept     = req_valid && req_ready;
  assign fault_push = (state_q == ST_RUN) && misalign && (q_count < CNT_W'(Q_DEPTH));
  // The redirect flushes the queue, so anything issued alongside it is dropped.
  assign push       = (accept || fault_push) && !hard_redir;
  assign pop        = out_valid && out_ready;

  assign push_mask = fault_push ? '1 : lane_mask;
  assign push_ent  = {pc_q, push_mask, fault_push, fault_push ? EXC_ADEL : EXC_NO_EX};

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (hard_redir) begin
      pc_d    = redir_pc;
      state_d = ST_RUN;
    end else if (accept) begin
      pc_d = bpu_valid ? bpu_target : ((pc_q & ~(GRP_BYTES - 32'd1)) + GRP_BYTES);
    end else if (fault_push) begin
      state_d = ST_FAULT;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  fetch_pc_fifo #(
    .WIDTH(ENT_W),
    .DEPTH(Q_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(hard_redir),
    .wdata_i(push_ent),
    .rdata_o(head_ent),
    .full_o (q_full),
    .empty_o(q_empty),
    .count_o(q_count)
  );

  // Head fields are forced to zero when empty so reset shows a clean bus.
  assign out_valid   = !q_empty;
  assign out_pc      = out_valid ? head_ent[ENT_W-1 -: PC_W] : '0;
  assign out_mask    = out_valid ? head_ent[EXC_W+EX_W +: FETCH_WIDTH] : '0;
  assign out_ex      = out_valid ? head_ent[EXC_W] : 1'b0;
  assign out_exccode = out_valid ? head_ent[EXC_W-1:0] : '0;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen with a queue-based reference model checked
// every cycle, plus literal expectations at the key scenario points.
module tb_fetch_pc_gen;

  localparam int          FW = 2;
  localparam int          QD = 4;
  localparam logic [31:0] RPC = 32'hBFC00000;

  logic          clk = 1'b0, resetn = 1'b1;
  logic          eret_valid = 0, ex_flush = 0, br_redirect = 0, bpu_valid = 0;
  logic [31:0]   eret_pc = 0, ex_pc = 0, br_target = 0, bpu_target = 0;
  logic          req_valid, req_ready = 0, out_valid, out_ready = 0;
  logic [31:0]   req_pc, out_pc;
  logic [FW-1:0] out_mask;
  logic          out_ex;
  logic [4:0]    out_exccode;

  always #5 clk = ~clk;

  fetch_pc_gen #(.FETCH_WIDTH(FW), .Q_DEPTH(QD), .RESET_PC(RPC)) dut (
    .clk(clk), .resetn(resetn),
    .eret_valid(eret_valid), .eret_pc(eret_pc),
    .ex_flush(ex_flush), .ex_pc(ex_pc),
    .br_redirect(br_redirect), .br_target(br_target),
    .bpu_valid(bpu_valid), .bpu_target(bpu_target),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_mask(out_mask), .out_ex(out_ex), .out_exccode(out_exccode)
  );

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: next PC, fault flag and a FIFO of expected entries.
  typedef struct {
    logic [31:0] pc;
    int          mask;
    bit          ex;
    int          code;
  } ment_t;

  ment_t       mq[$];
  logic [31:0] m_pc = RPC;
  bit          m_fault = 0;

  function automatic int grp_mask(input logic [31:0] pc);
    int wo;
    wo = int'((pc / 4) % FW);
    return ((1 << FW) - 1) & ~((1 << wo) - 1);
  endfunction

  function automatic bit m_req_valid();
    return (mq.size() < QD) && !m_fault && (m_pc % 4 == 0);
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      mq.delete();
      m_pc    = RPC;
      m_fault = 0;
    end else begin
      bit    rv, hard;
      ment_t e;
      rv   = m_req_valid();
      hard = eret_valid || ex_flush || br_redirect;
      if (hard) begin
        mq.delete();
        m_pc    = eret_valid ? eret_pc : (ex_flush ? ex_pc : br_target);
        m_fault = 0;
      end else begin
        bit room;
        room = mq.size() < QD;
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        if (rv && req_ready) begin
          e = '{pc: m_pc, mask: grp_mask(m_pc), ex: 0, code: 0};
          mq.push_back(e);
          m_pc = bpu_valid ? bpu_target : (m_pc / (FW * 4)) * (FW * 4) + FW * 4;
        end else if (!m_fault && (m_pc % 4 != 0) && room) begin
          e = '{pc: m_pc, mask: (1 << FW) - 1, ex: 1, code: 4};
          mq.push_back(e);
          m_fault = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_req_valid", 64'(req_valid), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_req_pc", 64'(req_pc), 64'(RPC));
      chk("rst_out_pc", 64'(out_pc), 64'd0);
      chk("rst_out_mask", 64'(out_mask), 64'd0);
      chk("rst_out_ex", 64'(out_ex), 64'd0);
      chk("rst_out_exccode", 64'(out_exccode), 64'd0);
    end else begin
      chk("m_req_pc", 64'(req_pc), 64'(m_pc));
      chk("m_req_valid", 64'(req_valid), 64'(m_req_valid()));
      chk("m_out_valid", 64'(out_valid), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("m_out_pc", 64'(out_pc), 64'(mq[0].pc));
        chk("m_out_mask", 64'(out_mask), 64'(mq[0].mask));
        chk("m_out_ex", 64'(out_ex), 64'(mq[0].ex));
        chk("m_out_exccode", 64'(out_exccode), 64'(mq[0].code));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    #1 resetn = 0;
    req_ready = 1;
    out_ready = 1;
    repeat (3) step();
    chk("lit_rst_req_pc", 64'(req_pc), 64'hBFC00000);
    chk("lit_rst_out_valid", 64'(out_valid), 64'd0);
    resetn = 1;
    #1;
    chk("lit_first_req_valid", 64'(req_valid), 64'd1);
    chk("lit_first_req_pc", 64'(req_pc), 64'hBFC00000);
    step();
    chk("lit_seq1_req_pc", 64'(req_pc), 64'hBFC00008);
    chk("lit_seq1_out_pc", 64'(out_pc), 64'hBFC00000);
    chk("lit_seq1_out_mask", 64'(out_mask), 64'd3);
    step();
    chk("lit_seq2_req_pc", 64'(req_pc), 64'hBFC00010);
    chk("lit_seq2_out_pc", 64'(out_pc), 64'hBFC00008);
    chk("lit_seq2_out_mask", 64'(out_mask), 64'd3);

    // branch redirect into the middle of a group
    br_target = 32'h80000004; br_redirect = 1;
    step();
    br_redirect = 0;
    chk("lit_br_req_pc", 64'(req_pc), 64'h80000004);
    chk("lit_br_flushed", 64'(out_valid), 64'd0);
    step();
    chk("lit_br_out_pc", 64'(out_pc), 64'h80000004);
    chk("lit_br_out_mask", 64'(out_mask), 64'd2);
    chk("lit_br_next_pc", 64'(req_pc), 64'h80000008);

    // backpressure fills the queue
    br_target = 32'h80000100; br_redirect = 1;
    step();
    br_redirect = 0;
    out_ready = 0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (req_valid && req_ready) acc++;
      step();
    end
    chk("lit_full_accepts", 64'(acc), 64'd4);
    chk("lit_full_req_valid", 64'(req_valid), 64'd0);
    out_ready = 1;
    step();
    out_ready = 0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      if (req_valid && req_ready) acc++;
      step();
    end
    chk("lit_refill_accepts", 64'(acc), 64'd1);

    // misaligned target -> AdEL entry and fault hold
    out_ready = 1;
    br_target = 32'h80000002; br_redirect = 1;
    step();
    br_redirect = 0;
    chk("lit_mis_req_valid", 64'(req_valid), 64'd0);
    step();
    chk("lit_fault_valid", 64'(out_valid), 64'd1);
    chk("lit_fault_ex", 64'(out_ex), 64'd1);
    chk("lit_fault_code", 64'(out_exccode), 64'h04);
    chk("lit_fault_mask", 64'(out_mask), 64'd3);
    chk("lit_fault_pc", 64'(out_pc), 64'h80000002);
    repeat (3) step();
    chk("lit_fault_hold", 64'(req_valid), 64'd0);
    chk("lit_fault_single", 64'(out_valid), 64'd0);
    ex_pc = 32'hBFC00380; ex_flush = 1;
    step();
    ex_flush = 0;
    chk("lit_exf_req_pc", 64'(req_pc), 64'hBFC00380);
    chk("lit_exf_req_valid", 64'(req_valid), 64'd1);

    // all redirects together with an accept: eret wins, nothing pushed
    eret_pc = 32'h80001000; eret_valid = 1;
    ex_pc = 32'h90000000; ex_flush = 1;
    br_target = 32'hA0000000; br_redirect = 1;
    bpu_target = 32'hC0000000; bpu_valid = 1;
    chk("lit_prio_accepting", 64'(req_valid && req_ready), 64'd1);
    step();
    eret_valid = 0; ex_flush = 0; br_redirect = 0; bpu_valid = 0;
    chk("lit_prio_req_pc", 64'(req_pc), 64'h80001000);
    chk("lit_prio_no_push", 64'(out_valid), 64'd0);

    // predicted-taken target
    bpu_target = 32'h80002000; bpu_valid = 1;
    step();
    bpu_valid = 0;
    chk("lit_bpu_req_pc", 64'(req_pc), 64'h80002000);
    chk("lit_bpu_out_pc", 64'(out_pc), 64'h80001000);

    // reset with three queued entries
    out_ready = 0;
    repeat (2) step();
    chk("lit_pre_rst_valid", 64'(out_valid), 64'd1);
    resetn = 0;
    #1;
    chk("lit_midrst_out_valid", 64'(out_valid), 64'd0);
    chk("lit_midrst_req_valid", 64'(req_valid), 64'd0);
    chk("lit_midrst_out_pc", 64'(out_pc), 64'd0);
    repeat (2) step();
    resetn = 1;
    out_ready = 1;
    #1;
    chk("lit_post_rst_req_pc", 64'(req_pc), 64'hBFC00000);
    chk("lit_post_rst_req_valid", 64'(req_valid), 64'd1);
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
